cnn_result_rx: RTL and testbench

CNN_RESULT_RX -- requirements
Module: cnn_result_rx

---
 rtl/cnn_pkg.sv | 12 +
 rtl/cnn_argmax_step.sv | 21 ++
 rtl/cnn_result_rx.sv | 135 +++++++++++++
 tb/tb_cnn_result_rx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and default parameters for the CNN result receiver.
package cnn_pkg;

    typedef enum logic {
        RECV = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int NUM_CLASSES_DEF = 10;
    localparam int DATA_W_DEF      = 32;

endpackage

// File: rtl/cnn_argmax_step.sv
// One signed compare-and-select step of the running argmax.
module cnn_argmax_step #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic [DATA_W-1:0] cur_max,
    input  logic [IDX_W-1:0]  cur_idx,
    input  logic [DATA_W-1:0] new_val,
    input  logic [IDX_W-1:0]  new_idx,
    output logic [DATA_W-1:0] next_max,
    output logic [IDX_W-1:0]  next_idx
);

    logic w_take;

    // Strictly greater only, so ties keep the earlier (lower) index.
    assign w_take   = $signed(new_val) > $signed(cur_max);
    assign next_max = w_take ? new_val : cur_max;
    assign next_idx = w_take ? new_idx : cur_idx;

endmodule

// File: rtl/cnn_result_rx.sv
// Receives one frame of class scores over AXI-Stream and reports the argmax.
// Optional score read-back buffer is enabled by CNN_RESULT_RX_SCORE_BUF_EN.
//
// state | meaning
// RECV  | accepting score beats, tracking running maximum
// HOLD  | result presented, waiting for result_ready
module cnn_result_rx
    import cnn_pkg::*;
#(
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic                s00_axis_aclk,
    input  logic                s00_axis_aresetn,
    output logic                s00_axis_tready,
    input  logic [DATA_W-1:0]   s00_axis_tdata,
    input  logic [DATA_W/8-1:0] s00_axis_tstrb,
    input  logic                s00_axis_tlast,
    input  logic                s00_axis_tvalid,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [3:0]          result_class,
    output logic [DATA_W-1:0]   result_score,
`ifdef CNN_RESULT_RX_SCORE_BUF_EN
    input  logic [3:0]          rd_addr,
    output logic [DATA_W-1:0]   rd_data,
`endif
    output logic                frame_err
);

    localparam logic [4:0] LP_NC   = 5'(NUM_CLASSES);
    localparam logic [4:0] LP_LAST = 5'(NUM_CLASSES - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [4:0]          r_cnt;
    logic [DATA_W-1:0]   r_max;
    logic [3:0]          r_idx;
    logic [3:0]          r_res_class;
    logic [DATA_W-1:0]   r_res_score;
    logic                r_err;

    logic                w_beat;
    logic                w_counted;
    logic                w_first;
    logic [DATA_W-1:0]   w_cur_max;
    logic [3:0]          w_cur_idx;
    logic [DATA_W-1:0]   w_next_max;
    logic [3:0]          w_next_idx;
    logic                w_unused;

    assign w_unused = ^s00_axis_tstrb;

    assign s00_axis_tready = (r_state == RECV) && s00_axis_aresetn;
    assign result_valid    = (r_state == HOLD);
    assign result_class    = r_res_class;
    assign result_score    = r_res_score;
    assign frame_err       = r_err;

    assign w_beat    = s00_axis_tvalid && s00_axis_tready;
    assign w_counted = w_beat && (r_cnt < LP_NC);
    assign w_first   = (r_cnt == 5'd0);

    // First beat compares against itself, which loads it unconditionally at index 0.
    assign w_cur_max = w_first ? s00_axis_tdata : r_max;
    assign w_cur_idx = w_first ? 4'd0 : r_idx;

    cnn_argmax_step #(
        .DATA_W (DATA_W),
        .IDX_W  (4)
    ) u_step (
        .cur_max  (w_cur_max),
        .cur_idx  (w_cur_idx),
        .new_val  (s00_axis_tdata),
        .new_idx  (r_cnt[3:0]),
        .next_max (w_next_max),
        .next_idx (w_next_idx)
    );

    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            r_state <= RECV;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RECV: if (w_beat && s00_axis_tlast) w_next_state = HOLD;
            HOLD: if (result_ready)             w_next_state = RECV;
            default: w_next_state = RECV;
        endcase
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            r_cnt       <= '0;
            r_max       <= '0;
            r_idx       <= '0;
            r_res_class <= '0;
            r_res_score <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_counted) begin
                r_cnt <= r_cnt + 5'd1;
                r_max <= w_next_max;
                r_idx <= w_next_idx;
            end
            if (w_beat && s00_axis_tlast) begin
                r_res_class <= w_counted ? w_next_idx : r_idx;
                r_res_score <= w_counted ? w_next_max : r_max;
                // Saturated counter makes any long frame land here too.
                r_err       <= (r_cnt != LP_LAST);
            end
            if (r_state == HOLD && result_ready) begin
                r_cnt <= '0;
            end
        end
    end

`ifdef CNN_RESULT_RX_SCORE_BUF_EN
    logic [DATA_W-1:0] r_buf [NUM_CLASSES];

    always_ff @(posedge s00_axis_aclk) begin
        if (w_counted) begin
            r_buf[r_cnt[3:0]] <= s00_axis_tdata;
        end
    end

    assign rd_data = ({1'b0, rd_addr} < LP_NC) ? r_buf[rd_addr] : '0;
`endif

endmodule

// File: tb/tb_cnn_result_rx.sv
// Directed self-checking bench for cnn_result_rx (default parameters).
module tb_cnn_result_rx;

    logic        clk;
    logic        aresetn;
    logic        tready;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast;
    logic        tvalid;
    logic        result_valid;
    logic        result_ready;
    logic [3:0]  result_class;
    logic [31:0] result_score;
    logic        frame_err;
`ifdef CNN_RESULT_RX_SCORE_BUF_EN
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
`endif

    int n_pass = 0;
    int n_total = 0;
    int fv[16];
    int fa[16] = '{3, -5, 7, 2, 7, 1, 0, -1, 6, 4, 0, 0, 0, 0, 0, 0};

    cnn_result_rx dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (aresetn),
        .s00_axis_tready  (tready),
        .s00_axis_tdata   (tdata),
        .s00_axis_tstrb   (tstrb),
        .s00_axis_tlast   (tlast),
        .s00_axis_tvalid  (tvalid),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .result_class     (result_class),
        .result_score     (result_score),
`ifdef CNN_RESULT_RX_SCORE_BUF_EN
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
`endif
        .frame_err        (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends fv[0..n-1] back to back; tlast on the final beat. Leaves at a negedge with tvalid=0.
    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tvalid = 1'b1;
            tdata  = fv[i];
            tlast  = (i == n - 1);
            @(posedge clk);
        end
        @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = '0;
    endtask

    task automatic ack();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk("ack_valid_low", {31'd0, result_valid}, 32'd0);
        chk("ack_tready_high", {31'd0, tready}, 32'd1);
    endtask

    initial begin
        logic [31:0] hold_cls, hold_score;
        logic        hold_err;
        bit          stable, nready;

        aresetn = 1'b0; tvalid = 1'b0; tdata = '0; tstrb = '1; tlast = 1'b0;
        result_ready = 1'b0;
`ifdef CNN_RESULT_RX_SCORE_BUF_EN
        rd_addr = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", {31'd0, tready}, 32'd0);
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_class", {28'd0, result_class}, 32'd0);
        chk("rst_score", result_score, 32'd0);
        chk("rst_err", {31'd0, frame_err}, 32'd0);
        aresetn = 1'b1;
        @(negedge clk);
        chk("post_rst_tready", {31'd0, tready}, 32'd1);

        // Nominal frame: maximum 7 first appears at index 2.
        fv = fa;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            tvalid = 1'b1; tdata = fv[i]; tlast = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        chk("a_valid_before_last", {31'd0, result_valid}, 32'd0);
        tvalid = 1'b1; tdata = fv[9]; tlast = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0;
        chk("a_valid", {31'd0, result_valid}, 32'd1);
        chk("a_class", {28'd0, result_class}, 32'd2);
        chk("a_score", result_score, 32'd7);
        chk("a_err", {31'd0, frame_err}, 32'd0);
        chk("a_tready_hold", {31'd0, tready}, 32'd0);
`ifdef CNN_RESULT_RX_SCORE_BUF_EN
        for (int i = 0; i < 10; i++) begin
            rd_addr = 4'(i);
            #1;
            chk($sformatf("buf_rd%0d", i), rd_data, 32'(fa[i]));
        end
        rd_addr = 4'd12;
        #1;
        chk("buf_rd12", rd_data, 32'd0);
`endif
        ack();

        // All equal negative scores: lowest index wins.
        for (int i = 0; i < 10; i++) fv[i] = -100;
        send_frame(10);
        chk("neg_class", {28'd0, result_class}, 32'd0);
        chk("neg_score", result_score, 32'hFFFF_FF9C);
        chk("neg_err", {31'd0, frame_err}, 32'd0);
        ack();

        // Short frame of 6 beats.
        fv = '{1, 9, 3, 9, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(6);
        chk("short_valid", {31'd0, result_valid}, 32'd1);
        chk("short_class", {28'd0, result_class}, 32'd1);
        chk("short_score", result_score, 32'd9);
        chk("short_err", {31'd0, frame_err}, 32'd1);
        ack();

        // Long frame of 12 beats: indices 10 and 11 are ignored.
        fv = '{5, 4, 3, 2, 1, 0, 8, 1, 1, 1, 2, 100, 0, 0, 0, 0};
        send_frame(12);
        chk("long_class", {28'd0, result_class}, 32'd6);
        chk("long_score", result_score, 32'd8);
        chk("long_err", {31'd0, frame_err}, 32'd1);
        ack();

        // Backpressure: hold result for 20 cycles while a master pushes data.
        fv = '{-3, -7, -1, -2, -9, -4, -8, -5, -6, -10, 0, 0, 0, 0, 0, 0};
        send_frame(10);
        chk("bp_class", {28'd0, result_class}, 32'd2);
        chk("bp_score", result_score, 32'hFFFF_FFFF);
        hold_cls = {28'd0, result_class};
        hold_score = result_score;
        hold_err = frame_err;
        stable = 1'b1;
        nready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tvalid = 1'b1; tlast = 1'b1; tdata = 32'd1000 + 32'(c);
            @(negedge clk);
            if (!result_valid || {28'd0, result_class} !== hold_cls ||
                result_score !== hold_score || frame_err !== hold_err)
                stable = 1'b0;
            if (tready !== 1'b0) nready = 1'b0;
        end
        chk("bp_stable", {31'd0, stable}, 32'd1);
        chk("bp_tready_low", {31'd0, nready}, 32'd1);
        tvalid = 1'b0; tlast = 1'b0; tdata = '0;
        ack();
        fv = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 50, 0, 0, 0, 0, 0, 0};
        send_frame(10);
        chk("bp_next_class", {28'd0, result_class}, 32'd9);
        chk("bp_next_score", result_score, 32'd50);
        chk("bp_next_err", {31'd0, frame_err}, 32'd0);
        ack();

        // Reset after beat 4 discards the partial frame.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tvalid = 1'b1; tdata = 32'd100; tlast = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        tvalid = 1'b0;
        aresetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, result_valid}, 32'd0);
        chk("mid_rst_tready", {31'd0, tready}, 32'd0);
        aresetn = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_post_valid", {31'd0, result_valid}, 32'd0);
        fv = fa;
        send_frame(10);
        chk("after_rst_valid", {31'd0, result_valid}, 32'd1);
        chk("after_rst_class", {28'd0, result_class}, 32'd2);
        chk("after_rst_score", result_score, 32'd7);
        chk("after_rst_err", {31'd0, frame_err}, 32'd0);
        ack();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
